// File: rtl/rotate_pkg.sv
// Shared constants and helpers for the rotate core and the channel arbiter in front of it.
package rotate_pkg;

  // Default pipeline latency of the rotate core, in cycles from ivalid to ovalid.
  localparam int ROTATE_PIPE_LAT = 4;

  // Width of a channel ID; never narrower than one bit.
  function automatic int ch_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/tag_fifo.sv
// Synchronous tag FIFO with wrap-bit pointers and a registered occupancy count.
module tag_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [PW-1:0]    wr_ptr_nxt, rd_ptr_nxt;
  logic [PW-1:0]    count;
  logic             push_ok, pop_ok;

  // Pushes into a full FIFO and pops from an empty one are dropped here.
  assign push_ok    = push & ~full;
  assign pop_ok     = pop & ~empty;
  assign wr_ptr_nxt = wr_ptr + PW'(push_ok);
  assign rd_ptr_nxt = rd_ptr + PW'(pop_ok);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr_nxt;
      rd_ptr <= rd_ptr_nxt;
      count  <= wr_ptr_nxt - rd_ptr_nxt;
    end
  end

  // NOTE: storage has no reset; the pointers alone define which entries are valid.
  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign pop_data = mem[rd_ptr[AW-1:0]];
  assign full     = (count == PW'(DEPTH));
  assign empty    = (count == '0);

endmodule

// File: rtl/rotate_arbiter.sv
// Round-robin front end sharing one rotate core between NUM_CH sample streams, with tag-based result return.
module rotate_arbiter
  import rotate_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int DATA_WIDTH  = 16,
  parameter int PHASE_WIDTH = 16,
  parameter int TAG_DEPTH   = 8
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_CH-1:0]             req_valid,
  output logic [NUM_CH-1:0]             req_ready,
  input  logic [NUM_CH*DATA_WIDTH-1:0]  req_data_r,
  input  logic [NUM_CH*DATA_WIDTH-1:0]  req_data_i,
  input  logic [NUM_CH*PHASE_WIDTH-1:0] req_phase,
  output logic                          rot_ivalid,
  output logic [DATA_WIDTH-1:0]         rot_idata_r,
  output logic [DATA_WIDTH-1:0]         rot_idata_i,
  output logic [PHASE_WIDTH-1:0]        rot_phase,
  input  logic                          rot_ovalid,
  input  logic [DATA_WIDTH-1:0]         rot_result_r,
  input  logic [DATA_WIDTH-1:0]         rot_result_i,
  output logic                          out_valid,
  output logic [$clog2(NUM_CH)-1:0]     out_ch,
  output logic [DATA_WIDTH-1:0]         out_r,
  output logic [DATA_WIDTH-1:0]         out_i,
  output logic                          err_orphan
);

  localparam int CH_W = ch_w(NUM_CH);

  logic [CH_W-1:0] last_grant;
  logic [CH_W-1:0] grant_idx;
  logic [CH_W-1:0] tag_head;
  logic            grant_found;
  logic            handshake;
  logic            tag_full, tag_empty;
  logic            result_ok;

  // Channel visited at step `offset` of a search that starts just after `base`.
  function automatic logic [CH_W-1:0] rr_index(input logic [CH_W-1:0] base, input int offset);
    int idx;
    idx = int'(base) + 1 + offset;
    if (idx >= NUM_CH) idx = idx - NUM_CH;
    return CH_W'(idx);
  endfunction

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    grant_idx   = '0;
    grant_found = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!grant_found && req_valid[rr_index(last_grant, i)]) begin
        grant_found = 1'b1;
        grant_idx   = rr_index(last_grant, i);
      end
    end
  end

  // The registered full flag gates grants, so a same-cycle pop never opens a slot early.
  always_comb begin
    req_ready = '0;
    if (grant_found && !tag_full && !reset) req_ready[grant_idx] = 1'b1;
  end

  assign handshake = |(req_valid & req_ready);
  assign result_ok = rot_ovalid & ~tag_empty;

  tag_fifo #(
    .WIDTH (CH_W),
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (handshake),
    .push_data (grant_idx),
    .pop       (rot_ovalid),
    .pop_data  (tag_head),
    .full      (tag_full),
    .empty     (tag_empty)
  );

  // Issue register: one sample per handshake, strobe lasts a single cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_grant  <= CH_W'(NUM_CH - 1);
      rot_ivalid  <= 1'b0;
      rot_idata_r <= '0;
      rot_idata_i <= '0;
      rot_phase   <= '0;
    end else begin
      rot_ivalid <= handshake;
      if (handshake) begin
        last_grant  <= grant_idx;
        rot_idata_r <= req_data_r[grant_idx*DATA_WIDTH +: DATA_WIDTH];
        rot_idata_i <= req_data_i[grant_idx*DATA_WIDTH +: DATA_WIDTH];
        rot_phase   <= req_phase[grant_idx*PHASE_WIDTH +: PHASE_WIDTH];
      end
    end
  end

  // Output register: pairs each core result with the oldest outstanding tag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_ch     <= '0;
      out_r      <= '0;
      out_i      <= '0;
      err_orphan <= 1'b0;
    end else begin
      out_valid <= result_ok;
      if (result_ok) begin
        out_ch <= tag_head;
        out_r  <= rot_result_r;
        out_i  <= rot_result_i;
      end
      if (rot_ovalid && tag_empty) err_orphan <= 1'b1;
    end
  end

endmodule
